fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one `FIFO` write port among `NREQ` producers. It grants ownership of the write port to one requester at a time, for bursts of up to `BURST` words. While it holds ownership it forwards that requester's data to the FIFO and stalls on `fifo_full`. It sits between the producer blocks and the FIFO's `data_in`/`we`/`fifo_full` pins.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: FSM encoding and default sizing
// used by both the arbiter and the FIFO top level.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_BURST = 4;
  localparam int unsigned DEF_WIDTH = 16;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request bit at or above base, wrapping
// modulo NREQ with explicit compare-and-subtract so non-power-of-two NREQ works.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] base,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [SUM_W-1:0] sum;
  logic [ID_W-1:0]  cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, base} + SUM_W'(i);
      if (sum >= SUM_W'(NREQ)) begin
        sum = sum - SUM_W'(NREQ);
      end
      cand = sum[ID_W-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, granting
// bursts of up to BURST words and stalling in place while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned width = DEF_WIDTH,
  parameter int unsigned BURST = DEF_BURST,
  parameter int unsigned ID_W  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*width-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_we,
  output logic [width-1:0]        fifo_data,
  output logic                    busy,
  output logic [ID_W-1:0]         owner_id
);

  localparam int unsigned BEAT_W = $clog2(BURST + 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ID_W-1:0]   owner_next;
  logic              wr;
  logic [width-1:0]  slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = req_data[g*width +: width];
  end

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req  (req),
    .base (rr_ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Pointer advance past the owner, wrapped explicitly for any NREQ.
  assign owner_next = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    wr        = 1'b0;
    fifo_we   = 1'b0;
    gnt       = '0;
    fifo_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          beat_d  = '0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        fifo_data = slice[owner_q];
        if (req[owner_q]) begin
          // Full with a pending word is a stall: all state holds.
          wr = !fifo_full;
          if (wr) begin
            fifo_we      = 1'b1;
            gnt[owner_q] = 1'b1;
            beat_d       = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BURST - 1)) begin
              state_d  = ST_IDLE;
              rr_ptr_d = owner_next;
            end
          end
        end else begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_OWN);
  assign owner_id = owner_q;

endmodule : fifo_wr_arbiter
